chess_turn_ctrl: RTL and testbench
==================================

CHESS_TURN_CTRL -- requirements
Module: chess_turn_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000000, clock cycles per countdown impulse (legal range 2..2^27).
REQ-002 SHALL have port CLK  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port CLR_N  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port START  input  1  one-cycle pulse: begin game from IDLE, or return to IDLE from FLAG.
REQ-005 SHALL have port PAUSE  input  1  one-cycle pulse: toggle between running and paused.
REQ-006 SHALL have port BTN_A  input  1  one-cycle pulse, pre-debounced: player A ends turn.
REQ-007 SHALL have port BTN_B  input  1  one-cycle pulse, pre-debounced: player B ends turn.
REQ-008 SHALL have port ZERO_A  input  1  high when all of player A's digit counters read 0.
REQ-009 SHALL have port ZERO_B  input  1  high when all of player B's digit counters read 0.
REQ-010 SHALL have port LOAD  output  1  one-cycle pulse to reload both players' counters to MAX.
REQ-011 SHALL have port CE_A  output  1  count enable for player A's counter chain.
REQ-012 SHALL have port CE_B  output  1  count enable for player B's counter chain.
REQ-013 SHALL have port TICK  output  1  one-cycle countdown impulse to the active chain's least-significant digit.
REQ-014 SHALL have port STATE  output  3  encoded state: IDLE=0, RUN_A=1, RUN_B=2, PAUSED=3, FLAG=4.
REQ-015 SHALL have port FLAG_A  output  1  player A lost on time.
REQ-016 SHALL have port FLAG_B  output  1  player B lost on time.
REQ-017 SHALL have port MOVES  output  8  completed full-move count, saturating.

Function
REQ-018 All outputs SHALL be registered; every input event sampled at edge k SHALL be visible on outputs from edge k onward (one-cycle latency).
REQ-019 IDLE: START -> RUN_A, with LOAD=1 for exactly that one cycle, MOVES<=0, FLAG_A/FLAG_B<=0; all other inputs ignored.
REQ-020 RUN_A: CE_A=1, CE_B=0; RUN_B: CE_B=1, CE_A=0; all other states: CE_A=CE_B=0.
REQ-021 Prescaler PRESC (27 bits) SHALL increment only in RUN_A/RUN_B; on PRESC==TICK_DIV-1 it SHALL wrap to 0 and TICK SHALL be 1 for the next cycle only.
REQ-022 PRESC SHALL clear to 0 on every entry into RUN_A or RUN_B (start, turn switch, resume); first TICK therefore appears TICK_DIV cycles after entry.
REQ-023 RUN_A: BTN_A -> RUN_B; BTN_B ignored. RUN_B: BTN_B -> RUN_A and MOVES<=MOVES+1, saturating at 255; BTN_A ignored.
REQ-024 RUN_x with ZERO_x=1 -> FLAG with FLAG_x<=1; timeout SHALL take priority over BTN_x and PAUSE in the same cycle.
REQ-025 ZERO of the non-active player SHALL be ignored.
REQ-026 RUN_x: PAUSE -> PAUSED, turn owner held in internal TURN bit; PRESC value frozen, not cleared.
REQ-027 PAUSED: PAUSE -> RUN_A or RUN_B per TURN, PRESC cleared per REQ-022; BTN_A/BTN_B/START ignored.
REQ-028 PAUSE simultaneous with BTN_x in RUN_x: turn switch SHALL win; PAUSE ignored.
REQ-029 FLAG: CE_A=CE_B=0, TICK=0, FLAG_x held; START -> IDLE with FLAG_A/FLAG_B, MOVES held until next game start.
REQ-030 START SHALL be ignored in RUN_A, RUN_B, PAUSED.
REQ-031 Undefined STATE encodings SHALL recover to IDLE on the next edge.

Reset
REQ-032 CLR_N=0 at an edge SHALL force STATE=IDLE, TURN=A, PRESC=0, LOAD=0, CE_A=CE_B=0, TICK=0, FLAG_A=FLAG_B=0, MOVES=0, overriding all other inputs, including mid-game and mid-PAUSED.
REQ-033 After CLR_N returns high the block SHALL wait in IDLE for START; LOAD SHALL not pulse without START.

Verification (TICK_DIV=4)
REQ-034 Reset, START at edge 0 -> LOAD=1 cycle 0 only, STATE=1, CE_A=1; TICK high in cycles 4, 8, 12.
REQ-035 RUN_A, BTN_A at edge 6 -> STATE=2, CE_B=1, CE_A=0 from cycle 6; next TICK cycle 10; BTN_B -> STATE=1, MOVES=1.
REQ-036 RUN_A, PAUSE at edge 5 -> STATE=3, no TICK for 20 cycles; PAUSE again -> STATE=1, TICK 4 cycles later.
REQ-037 RUN_B with ZERO_B=1 and BTN_B same edge -> STATE=4, FLAG_B=1, CE_B=0, MOVES unchanged; START -> STATE=0.
REQ-038 MOVES=255, BTN_B in RUN_B -> MOVES stays 255; CLR_N=0 mid-RUN_B -> all outputs per REQ-032 next cycle.

Source files
------------

// File: rtl/chess_turn_ctrl.sv
// chess_turn_ctrl: two-player chess clock controller with prescaled countdown tick
module chess_turn_ctrl #(
    parameter int unsigned TICK_DIV = 100000000
) (
    input  logic       CLK,
    input  logic       CLR_N,
    input  logic       START,
    input  logic       PAUSE,
    input  logic       BTN_A,
    input  logic       BTN_B,
    input  logic       ZERO_A,
    input  logic       ZERO_B,
    output logic       LOAD,
    output logic       CE_A,
    output logic       CE_B,
    output logic       TICK,
    output logic [2:0] STATE,
    output logic       FLAG_A,
    output logic       FLAG_B,
    output logic [7:0] MOVES
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN_A  = 3'd1,
        RUN_B  = 3'd2,
        PAUSED = 3'd3,
        FLAG   = 3'd4
    } state_t;

    localparam logic [26:0] PRESC_TOP = 27'(TICK_DIV - 1);

    state_t      state;
    logic        turn;
    logic [26:0] presc;
    logic        wrap;

    assign STATE = state;
    assign wrap  = presc == PRESC_TOP;

    // Game FSM; every output is a register updated alongside the next state
    always_ff @(posedge CLK) begin
        if (!CLR_N) begin
            state  <= IDLE;
            turn   <= 1'b0;
            presc  <= '0;
            LOAD   <= 1'b0;
            CE_A   <= 1'b0;
            CE_B   <= 1'b0;
            TICK   <= 1'b0;
            FLAG_A <= 1'b0;
            FLAG_B <= 1'b0;
            MOVES  <= '0;
        end else begin
            LOAD <= 1'b0;
            TICK <= 1'b0;
            CE_A <= 1'b0;
            CE_B <= 1'b0;
            case (state)
                IDLE: if (START) begin
                    state  <= RUN_A;
                    turn   <= 1'b0;
                    presc  <= '0;
                    LOAD   <= 1'b1;
                    CE_A   <= 1'b1;
                    MOVES  <= '0;
                    FLAG_A <= 1'b0;
                    FLAG_B <= 1'b0;
                end
                RUN_A: if (ZERO_A) begin
                    state  <= FLAG;
                    FLAG_A <= 1'b1;
                end else if (BTN_A) begin
                    state <= RUN_B;
                    turn  <= 1'b1;
                    presc <= '0;
                    CE_B  <= 1'b1;
                end else if (PAUSE) begin
                    state <= PAUSED;
                end else begin
                    CE_A  <= 1'b1;
                    presc <= wrap ? '0 : presc + 27'd1;
                    TICK  <= wrap;
                end
                RUN_B: if (ZERO_B) begin
                    state  <= FLAG;
                    FLAG_B <= 1'b1;
                end else if (BTN_B) begin
                    state <= RUN_A;
                    turn  <= 1'b0;
                    presc <= '0;
                    CE_A  <= 1'b1;
                    MOVES <= (MOVES == 8'hFF) ? MOVES : MOVES + 8'd1;
                end else if (PAUSE) begin
                    state <= PAUSED;
                end else begin
                    CE_B  <= 1'b1;
                    presc <= wrap ? '0 : presc + 27'd1;
                    TICK  <= wrap;
                end
                PAUSED: if (PAUSE) begin
                    state <= turn ? RUN_B : RUN_A;
                    presc <= '0;
                    CE_A  <= !turn;
                    CE_B  <= turn;
                end
                FLAG: if (START) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chess_turn_ctrl.sv
// tb_chess_turn_ctrl: directed-vector bench for chess_turn_ctrl with TICK_DIV=4
module tb_chess_turn_ctrl;

    logic       CLK = 1'b0;
    logic       CLR_N = 1'b0;
    logic       START = 1'b0, PAUSE = 1'b0, BTN_A = 1'b0, BTN_B = 1'b0;
    logic       ZERO_A = 1'b0, ZERO_B = 1'b0;
    logic       LOAD, CE_A, CE_B, TICK, FLAG_A, FLAG_B;
    logic [2:0] STATE;
    logic [7:0] MOVES;
    int         n_tests = 0;
    int         n_fail = 0;

    chess_turn_ctrl #(.TICK_DIV(4)) dut (
        .CLK(CLK), .CLR_N(CLR_N), .START(START), .PAUSE(PAUSE),
        .BTN_A(BTN_A), .BTN_B(BTN_B), .ZERO_A(ZERO_A), .ZERO_B(ZERO_B),
        .LOAD(LOAD), .CE_A(CE_A), .CE_B(CE_B), .TICK(TICK),
        .STATE(STATE), .FLAG_A(FLAG_A), .FLAG_B(FLAG_B), .MOVES(MOVES)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // one clock edge with the currently driven inputs, then drop all pulses
    task automatic cyc();
        @(posedge CLK);
        #1;
        START = 1'b0; PAUSE = 1'b0; BTN_A = 1'b0; BTN_B = 1'b0;
        ZERO_A = 1'b0; ZERO_B = 1'b0;
    endtask

    // reset then START at edge 0; returns sitting in cycle 0
    task automatic new_game();
        CLR_N = 1'b0;
        cyc();
        CLR_N = 1'b1;
        START = 1'b1;
        cyc();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, STATE, 0);
        check({tag, "_load"}, LOAD, 0);
        check({tag, "_ce_a"}, CE_A, 0);
        check({tag, "_ce_b"}, CE_B, 0);
        check({tag, "_tick"}, TICK, 0);
        check({tag, "_flag_a"}, FLAG_A, 0);
        check({tag, "_flag_b"}, FLAG_B, 0);
        check({tag, "_moves"}, MOVES, 0);
    endtask

    initial begin
        // reset, then idle without START; buttons ignored
        cyc();
        cyc();
        check_reset_outputs("rst");
        CLR_N = 1'b1;
        BTN_A = 1'b1;
        cyc();
        PAUSE = 1'b1;
        cyc();
        cyc();
        check("idle_state", STATE, 0);
        check("idle_load", LOAD, 0);
        check("idle_ce_a", CE_A, 0);

        // start and tick cadence
        START = 1'b1;
        cyc();
        check("start_load", LOAD, 1);
        check("start_state", STATE, 1);
        check("start_ce_a", CE_A, 1);
        check("start_ce_b", CE_B, 0);
        check("start_tick", TICK, 0);
        for (int k = 1; k <= 12; k++) begin
            cyc();
            check($sformatf("tick_c%0d", k), TICK, k % 4 == 0);
            check($sformatf("load_c%0d", k), LOAD, 0);
        end

        // turn switch at edge 6, with ignored ZERO_B and BTN_B in RUN_A
        new_game();
        for (int k = 1; k <= 5; k++) begin
            if (k == 2) ZERO_B = 1'b1;
            if (k == 3) BTN_B = 1'b1;
            cyc();
            check($sformatf("runa_state_c%0d", k), STATE, 1);
        end
        BTN_A = 1'b1;
        cyc();
        check("swb_state", STATE, 2);
        check("swb_ce_b", CE_B, 1);
        check("swb_ce_a", CE_A, 0);
        check("swb_tick", TICK, 0);
        for (int k = 7; k <= 10; k++) begin
            cyc();
            check($sformatf("runb_tick_c%0d", k), TICK, k == 10);
        end
        BTN_B = 1'b1;
        cyc();
        check("swa_state", STATE, 1);
        check("swa_moves", MOVES, 1);
        check("swa_ce_a", CE_A, 1);
        check("swa_ce_b", CE_B, 0);

        // pause at edge 5, 20 frozen cycles with ignored inputs, resume
        new_game();
        for (int k = 1; k <= 4; k++) cyc();
        check("pre_pause_tick", TICK, 1);
        PAUSE = 1'b1;
        cyc();
        check("pause_state", STATE, 3);
        check("pause_ce_a", CE_A, 0);
        check("pause_tick", TICK, 0);
        for (int i = 1; i <= 20; i++) begin
            if (i == 3) START = 1'b1;
            if (i == 7) BTN_A = 1'b1;
            if (i == 9) BTN_B = 1'b1;
            cyc();
            check($sformatf("paused_tick_%0d", i), TICK, 0);
            check($sformatf("paused_state_%0d", i), STATE, 3);
        end
        PAUSE = 1'b1;
        cyc();
        check("resume_state", STATE, 1);
        check("resume_ce_a", CE_A, 1);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            check($sformatf("resume_tick_c%0d", k), TICK, k == 4);
        end
        BTN_A = 1'b1;
        PAUSE = 1'b1;
        cyc();
        check("btn_over_pause_state", STATE, 2);
        check("btn_over_pause_ce_b", CE_B, 1);
        PAUSE = 1'b1;
        cyc();
        check("pause_b_state", STATE, 3);
        check("pause_b_ce_b", CE_B, 0);
        PAUSE = 1'b1;
        cyc();
        check("resume_b_state", STATE, 2);
        check("resume_b_ce_b", CE_B, 1);
        BTN_B = 1'b1;
        cyc();
        check("move1", MOVES, 1);
        BTN_A = 1'b1;
        cyc();
        check("back_b_state", STATE, 2);

        // timeouts
        ZERO_A = 1'b1;
        cyc();
        check("zero_a_in_b_state", STATE, 2);
        check("zero_a_in_b_flag", FLAG_A, 0);
        ZERO_B = 1'b1;
        BTN_B = 1'b1;
        cyc();
        check("flag_b_state", STATE, 4);
        check("flag_b_flag", FLAG_B, 1);
        check("flag_b_flag_a", FLAG_A, 0);
        check("flag_b_ce_b", CE_B, 0);
        check("flag_b_tick", TICK, 0);
        check("flag_b_moves", MOVES, 1);
        BTN_B = 1'b1;
        PAUSE = 1'b1;
        cyc();
        check("flag_hold_state", STATE, 4);
        START = 1'b1;
        cyc();
        check("flag_idle_state", STATE, 0);
        check("flag_idle_flag_b", FLAG_B, 1);
        check("flag_idle_moves", MOVES, 1);
        check("flag_idle_load", LOAD, 0);
        START = 1'b1;
        cyc();
        check("restart_state", STATE, 1);
        check("restart_load", LOAD, 1);
        check("restart_flag_b", FLAG_B, 0);
        check("restart_moves", MOVES, 0);
        ZERO_A = 1'b1;
        PAUSE = 1'b1;
        cyc();
        check("flag_a_state", STATE, 4);
        check("flag_a_flag", FLAG_A, 1);
        check("flag_a_ce_a", CE_A, 0);
        START = 1'b1;
        cyc();
        check("flag_a_idle", STATE, 0);

        // move counter saturation, then reset mid-RUN_B
        new_game();
        for (int i = 0; i < 255; i++) begin
            BTN_A = 1'b1;
            cyc();
            BTN_B = 1'b1;
            cyc();
        end
        check("moves_255", MOVES, 255);
        BTN_A = 1'b1;
        cyc();
        BTN_B = 1'b1;
        cyc();
        check("moves_sat", MOVES, 255);
        check("moves_sat_state", STATE, 1);
        BTN_A = 1'b1;
        cyc();
        check("pre_clr_state", STATE, 2);
        CLR_N = 1'b0;
        BTN_B = 1'b1;
        START = 1'b1;
        cyc();
        check_reset_outputs("clr_mid");
        CLR_N = 1'b1;
        cyc();
        check("post_clr_state", STATE, 0);
        check("post_clr_load", LOAD, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
